// File: rtl/util_dac_diff.sv
// util_dac_diff: slew-limited differential line-state to DAC sample stream,
// which ramps to midscale and drops wr_valid after a run of idle requests.
module util_dac_diff #(
  parameter int WORD_WIDTH   = 1,
  parameter int BYTE_WIDTH   = 1,
  parameter int HIGH_VAL     = 96,
  parameter int LOW_VAL      = -96,
  parameter int SLEW_STEP    = 32,
  parameter int NO_DIFF_WAIT = 50
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [1:0]                         diff_in,
  output logic [WORD_WIDTH*BYTE_WIDTH*8-1:0] wr_data,
  output logic                               wr_valid,
  input  logic                               wr_enable
);
  localparam int CW = $clog2(NO_DIFF_WAIT + 1);
  localparam logic [CW-1:0] WAIT_C = CW'(NO_DIFF_WAIT);
  localparam logic signed [9:0] SS = 10'(SLEW_STEP);
  localparam logic signed [7:0] SS8 = 8'(SLEW_STEP);
  localparam logic signed [7:0] HV = 8'(HIGH_VAL);
  localparam logic signed [7:0] LV = 8'(LOW_VAL);
  typedef enum logic [1:0] {IDLE, ACTIVE, RETURN} state_t;
  state_t state_q, state_d;
  logic signed [7:0] cur_q, cur_d, tgt;
  logic valid_q, valid_d, active, xfer;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  // 10-bit difference keeps tgt-cur exact, so the result never wraps or overshoots
  function automatic logic signed [7:0] step(input logic signed [7:0] c, input logic signed [7:0] t);
    logic signed [9:0] d;
    d = 10'(t) - 10'(c);
    return d > SS ? c + SS8 : (d < -SS ? c - SS8 : t);
  endfunction
  assign active  = diff_in[1] ^ diff_in[0];
  assign tgt     = diff_in == 2'b10 ? HV : (diff_in == 2'b01 ? LV : 8'sd0);
  assign xfer    = valid_q & wr_enable;
  assign cnt_inc = cnt_q == WAIT_C ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (active) begin
        state_d = ACTIVE;
        valid_d = 1'b1;
        cur_d   = step(8'sd0, tgt);
      end
      ACTIVE: begin
        cnt_d = active ? '0 : cnt_inc;
        if (xfer) cur_d = step(cur_q, tgt);
        if (!active && cnt_inc == WAIT_C) state_d = RETURN;
      end
      RETURN: if (active) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        if (xfer) cur_d = step(cur_q, tgt);
      end else if (xfer) begin
        if (cur_q == 8'sd0) begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else cur_d = step(cur_q, 8'sd0);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cur_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign wr_data  = {(WORD_WIDTH*BYTE_WIDTH){cur_q}};
  assign wr_valid = valid_q;
endmodule

// File: tb/tb_util_dac_diff.sv
// tb_util_dac_diff: directed vectors with literal expectations, plus a
// per-cycle compare against an integer behavioural model of the DAC stream.
module tb_util_dac_diff;
  localparam int HV = 96, LV = -96, SS = 32, NDW = 50;
  logic clk = 1'b0, rstn, wr_valid, wr_enable;
  logic [1:0] diff_in;
  logic [7:0] wr_data;
  int n_tests = 0, n_fail = 0;
  int m_cur = 0, m_mode = 0, m_cnt = 0;
  logic m_valid = 1'b0;
  always #5 clk = ~clk;
  util_dac_diff #(.WORD_WIDTH(1), .BYTE_WIDTH(1), .HIGH_VAL(HV), .LOW_VAL(LV),
                  .SLEW_STEP(SS), .NO_DIFF_WAIT(NDW)) dut (
    .clk(clk), .rstn(rstn), .diff_in(diff_in), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_enable(wr_enable));
  function automatic int stepf(input int c, input int t);
    int d = t - c;
    if (d <= SS && d >= -SS) return t;
    return d > 0 ? c + SS : c - SS;
  endfunction
  // mode: 0 quiet, 1 following requests, 2 draining to midscale
  always @(posedge clk) begin
    int t;
    bit act, xf;
    t   = diff_in == 2'b10 ? HV : (diff_in == 2'b01 ? LV : 0);
    act = diff_in[1] ^ diff_in[0];
    xf  = m_valid && wr_enable;
    if (!rstn) begin
      m_cur = 0; m_mode = 0; m_cnt = 0; m_valid = 1'b0;
    end else if (m_mode == 0) begin
      if (act) begin m_mode = 1; m_valid = 1'b1; m_cur = stepf(0, t); end
    end else if (act) begin
      m_mode = 1; m_cnt = 0;
      if (xf) m_cur = stepf(m_cur, t);
    end else if (m_mode == 1) begin
      if (m_cnt < NDW) m_cnt++;
      if (xf) m_cur = stepf(m_cur, 0);
      if (m_cnt == NDW) m_mode = 2;
    end else if (xf) begin
      if (m_cur == 0) begin m_mode = 0; m_valid = 1'b0; m_cnt = 0; end
      else m_cur = stepf(m_cur, 0);
    end
  end
  always @(negedge clk) begin
    n_tests++;
    if (wr_data !== 8'(m_cur) || wr_valid !== m_valid) begin
      n_fail++;
      $display("FAIL model t=%0t: data=%h valid=%b expected data=%h valid=%b",
               $time, wr_data, wr_valid, 8'(m_cur), m_valid);
    end
  end
  task automatic chk(input string nm, input logic [7:0] ed, input logic ev);
    n_tests++;
    if (wr_data !== ed || wr_valid !== ev) begin
      n_fail++;
      $display("FAIL %s: data=%h valid=%b expected data=%h valid=%b", nm, wr_data, wr_valid, ed, ev);
    end
  endtask
  task automatic drive(input logic [1:0] d, input logic en);
    diff_in = d;
    wr_enable = en;
    @(negedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] ramp[5] = '{8'h20, 8'h40, 8'h60, 8'h60, 8'h60};
    logic [7:0] rev[7]  = '{8'h40, 8'h20, 8'h00, 8'he0, 8'hc0, 8'ha0, 8'ha0};
    logic [7:0] up[5]   = '{8'hc0, 8'he0, 8'h00, 8'h20, 8'h40};
    rstn = 1'b0; diff_in = 2'b10; wr_enable = 1'b1;
    repeat (4) begin drive(2'b10, 1'b1); chk("reset", 8'h00, 1'b0); end
    rstn = 1'b1;
    chk("post_release", 8'h00, 1'b0);
    foreach (ramp[i]) begin drive(2'b10, 1'b1); chk("ramp", ramp[i], 1'b1); end
    foreach (rev[i]) begin drive(2'b01, 1'b1); chk("reversal", rev[i], 1'b1); end
    foreach (up[i]) begin drive(2'b10, 1'b1); chk("reramp", up[i], 1'b1); end
    repeat (5) begin drive(2'b10, 1'b0); chk("backpressure", 8'h40, 1'b1); end
    drive(2'b10, 1'b1); chk("bp_release", 8'h60, 1'b1);
    for (int i = 1; i <= NDW + 1; i++) begin
      drive(2'b00, 1'b1);
      chk("idle_timeout", i == 1 ? 8'h40 : (i == 2 ? 8'h20 : 8'h00), i <= NDW);
    end
    drive(2'b11, 1'b1); chk("idle11_stays", 8'h00, 1'b0);
    drive(2'b10, 1'b1); chk("wake", 8'h20, 1'b1);
    drive(2'b00, 1'b1); chk("drain", 8'h00, 1'b1);
    repeat (NDW + 4) drive(2'b00, 1'b0);
    chk("stall_in_return", 8'h00, 1'b1);
    drive(2'b00, 1'b1); chk("return_exit", 8'h00, 1'b0);
    repeat (3) drive(2'b10, 1'b1);
    chk("rearm", 8'h60, 1'b1);
    repeat (NDW + 1) drive(2'b00, 1'b0);
    chk("return_held", 8'h60, 1'b1);
    drive(2'b00, 1'b1); chk("ret_step1", 8'h40, 1'b1);
    drive(2'b00, 1'b1); chk("ret_step2", 8'h20, 1'b1);
    drive(2'b01, 1'b1); chk("reactivate", 8'h00, 1'b1);
    drive(2'b01, 1'b1); chk("reactivate2", 8'he0, 1'b1);
    for (int i = 1; i <= NDW + 1; i++) begin
      drive(2'b00, 1'b1);
      if (i >= NDW) chk("cnt_cleared", 8'h00, i == NDW);
    end
    repeat (2) drive(2'b01, 1'b1);
    chk("neg_ramp", 8'hc0, 1'b1);
    rstn = 1'b0;
    drive(2'b01, 1'b1); chk("mid_reset", 8'h00, 1'b0);
    rstn = 1'b1;
    drive(2'b01, 1'b0); chk("after_reset", 8'he0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
